uart_rx_param: RTL and testbench

Parametrised UART receiver: the next-generation serial input stage of the UART, replacing the fixed 8N1 receiver. It oversamples `serial_in` on a clock-enable tick and supports 5–9 data bits, none/even/odd parity, and 1 or 2 stop bits. Each bit is decided by a 3-sample majority vote. Received words go to the consumer through a one-entry valid/ready holding register with overrun reporting. Start-bit glitches and framing errors are fatal: the receiver stays in error until reset.

---
 rtl/uart_rx_param.sv | 169 ++++++++++++++++
 tb/tb_uart_rx_param.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 3-sample majority per bit, 5..9 data bits, optional parity,
// 1 or 2 stop bits, one-entry valid/ready holding register with overrun pulse, sticky fatal error.
module uart_rx_param #(
    parameter int P_DATA_BITS   = 8,
    parameter int P_PARITY      = 0,
    parameter int P_STOP_BITS   = 1,
    parameter int P_OVS         = 16,
    parameter int P_REG_MODE_TH = 160
) (
    input  logic                   CLK,
    input  logic                   reset,
    input  logic                   serial_in,
    input  logic                   x16_BAUD,
    input  logic                   ready,
    output logic [P_DATA_BITS-1:0] Do,
    output logic                   valid,
    output logic                   parity_err,
    output logic                   overrun,
    output logic                   error
);

    localparam int TW = $clog2(P_OVS);
    localparam int SW = $clog2(P_REG_MODE_TH + 1);

    localparam logic [TW-1:0] T_S0  = TW'(P_OVS / 2 - 1);
    localparam logic [TW-1:0] T_S1  = TW'(P_OVS / 2);
    localparam logic [TW-1:0] T_DEC = TW'(P_OVS / 2 + 1);
    localparam logic [TW-1:0] T_END = TW'(P_OVS - 1);
    localparam logic [SW-1:0] SYNC_TH   = SW'(P_REG_MODE_TH);
    localparam logic [3:0]    LAST_DATA = 4'(P_DATA_BITS - 1);
    localparam logic [3:0]    LAST_STOP = 4'(P_STOP_BITS - 1);
    localparam logic          HAS_PAR   = (P_PARITY != 0);
    localparam logic          ODD_PAR   = (P_PARITY == 2);

    typedef enum logic [2:0] {
        S_SYNC, S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_ERROR
    } state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
        return (v == SYNC_TH) ? v : v + SW'(1);
    endfunction

    state_t                 state;
    logic                   sync_p0, sync_p1;
    logic [TW-1:0]          tick_cnt;
    logic [3:0]             bit_cnt;
    logic [SW-1:0]          sync_cnt;
    logic                   smp0, smp1;
    logic [P_DATA_BITS-1:0] shreg;
    logic                   par_bad;
    logic                   rx, bit_val, dec_tick, end_tick;

    assign rx       = sync_p1;
    assign bit_val  = maj3(smp0, smp1, rx);
    assign dec_tick = (tick_cnt == T_DEC);
    assign end_tick = (tick_cnt == T_END);

    // Stage p0/p1: two-flop synchronizer, idles high out of reset
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
        end else begin
            sync_p0 <= serial_in;
            sync_p1 <= sync_p0;
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state      <= S_SYNC;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            sync_cnt   <= '0;
            smp0       <= 1'b1;
            smp1       <= 1'b1;
            shreg      <= '0;
            par_bad    <= 1'b0;
            Do         <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
            error      <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (valid && ready)
                valid <= 1'b0;

            if (x16_BAUD) begin
                if (state inside {S_START, S_DATA, S_PARITY, S_STOP}) begin
                    tick_cnt <= end_tick ? '0 : tick_cnt + TW'(1);
                    if (tick_cnt == T_S0) smp0 <= rx;
                    if (tick_cnt == T_S1) smp1 <= rx;
                end

                case (state)
                    S_SYNC: begin
                        sync_cnt <= rx ? sat_inc(sync_cnt) : '0;
                        if (rx && sat_inc(sync_cnt) == SYNC_TH)
                            state <= S_IDLE;
                    end
                    S_IDLE: begin
                        // The detecting tick is index 0 of the start bit
                        if (!rx) begin
                            state    <= S_START;
                            tick_cnt <= TW'(1);
                        end
                    end
                    S_START: begin
                        if (dec_tick && bit_val) begin
                            state <= S_ERROR;
                            error <= 1'b1;
                        end else if (end_tick) begin
                            state   <= S_DATA;
                            bit_cnt <= '0;
                        end
                    end
                    S_DATA: begin
                        if (dec_tick)
                            shreg <= {bit_val, shreg[P_DATA_BITS-1:1]};
                        if (end_tick) begin
                            if (bit_cnt == LAST_DATA) begin
                                state   <= HAS_PAR ? S_PARITY : S_STOP;
                                bit_cnt <= '0;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    S_PARITY: begin
                        if (dec_tick)
                            par_bad <= bit_val ^ (^shreg) ^ ODD_PAR;
                        if (end_tick) begin
                            state   <= S_STOP;
                            bit_cnt <= '0;
                        end
                    end
                    S_STOP: begin
                        if (dec_tick) begin
                            if (!bit_val) begin
                                state <= S_ERROR;
                                error <= 1'b1;
                            end else if (bit_cnt == LAST_STOP) begin
                                // Leave mid-bit so an immediately following start edge is caught
                                state <= S_IDLE;
                                if (!valid || ready) begin
                                    Do         <= shreg;
                                    parity_err <= HAS_PAR & par_bad;
                                    valid      <= 1'b1;
                                end else begin
                                    overrun <= 1'b1;
                                end
                            end
                        end else if (end_tick) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    S_ERROR: ;
                    default: state <= S_ERROR;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: default 8N1 instance (A) and a 7-bit odd-parity 2-stop instance (B),
// driven with directed frames; received words checked against a queue of expected words.
`timescale 1ns/1ps
module tb_uart_rx_param;

    logic clk = 1'b0;
    logic x16 = 1'b0;
    int   tcnt = 0;

    logic       rst_a, ser_a, rdy_a;
    logic [7:0] do_a;
    logic       vld_a, perr_a, ovr_a, err_a;

    logic       rst_b, ser_b, rdy_b;
    logic [6:0] do_b;
    logic       vld_b, perr_b, ovr_b, err_b;

    typedef struct packed {
        logic [8:0] data;
        logic       perr;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    int tests  = 0;
    int fails  = 0;
    int novr_a = 0;
    int novr_b = 0;

    uart_rx_param dut_a (
        .CLK(clk), .reset(rst_a), .serial_in(ser_a), .x16_BAUD(x16), .ready(rdy_a),
        .Do(do_a), .valid(vld_a), .parity_err(perr_a), .overrun(ovr_a), .error(err_a)
    );

    uart_rx_param #(.P_DATA_BITS(7), .P_PARITY(2), .P_STOP_BITS(2)) dut_b (
        .CLK(clk), .reset(rst_b), .serial_in(ser_b), .x16_BAUD(x16), .ready(rdy_b),
        .Do(do_b), .valid(vld_b), .parity_err(perr_b), .overrun(ovr_b), .error(err_b)
    );

    initial forever #5 clk = ~clk;

    // One oversample tick every 9 clocks, changed on the falling edge
    initial forever begin
        @(negedge clk);
        tcnt = (tcnt == 8) ? 0 : tcnt + 1;
        x16  = (tcnt == 0);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, want);
        end
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (!x16) @(posedge clk);
        end
        #1;
    endtask

    task automatic drive(input bit sel, input logic v, input int n);
        if (sel) ser_b = v;
        else     ser_a = v;
        wait_ticks(n);
    endtask

    task automatic send_bits(input bit sel, input int nbits, input logic [15:0] bits);
        for (int i = 0; i < nbits; i++)
            drive(sel, bits[i], 16);
    endtask

    task automatic frame_a(input logic [7:0] d, input logic stop);
        send_bits(1'b0, 10, {6'b0, stop, d, 1'b0});
    endtask

    task automatic frame_b(input logic [6:0] d, input logic par, input logic stop2);
        send_bits(1'b1, 11, {5'b0, stop2, 1'b1, par, d, 1'b0});
    endtask

    task automatic expect_a(input logic [7:0] d);
        q_a.push_back('{data: {1'b0, d}, perr: 1'b0});
    endtask

    task automatic expect_b(input logic [6:0] d, input logic pe);
        q_b.push_back('{data: {2'b0, d}, perr: pe});
    endtask

    // Scoreboard monitors: pop on every handshake, count overrun pulses
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (vld_a && rdy_a) begin
            if (q_a.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL A_unexpected_word: got Do=%0h, no word expected", do_a);
            end else begin
                e = q_a.pop_front();
                check("A_Do", 32'(do_a), 32'(e.data));
                check("A_parity_err", 32'(perr_a), 32'(e.perr));
            end
        end
        if (ovr_a) novr_a++;
    end

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (vld_b && rdy_b) begin
            if (q_b.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL B_unexpected_word: got Do=%0h, no word expected", do_b);
            end else begin
                e = q_b.pop_front();
                check("B_Do", 32'(do_b), 32'(e.data));
                check("B_parity_err", 32'(perr_b), 32'(e.perr));
            end
        end
        if (ovr_b) novr_b++;
    end

    initial begin
        ser_a = 1'b1; ser_b = 1'b1;
        rst_a = 1'b0; rst_b = 1'b0;
        rdy_a = 1'b0; rdy_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("A_reset_Do", 32'(do_a), 32'h0);
        check("A_reset_valid", 32'(vld_a), 32'h0);
        check("A_reset_parity_err", 32'(perr_a), 32'h0);
        check("A_reset_overrun", 32'(ovr_a), 32'h0);
        check("A_reset_error", 32'(err_a), 32'h0);
        wait_ticks(1);
        rst_a = 1'b1;
        rst_b = 1'b1;

        // Start-bit glitch is fatal
        drive(1'b0, 1'b1, 200);
        drive(1'b0, 1'b0, 1);
        drive(1'b0, 1'b1, 20);
        check("A_glitch_error", 32'(err_a), 32'h1);
        check("A_glitch_valid", 32'(vld_a), 32'h0);
        rst_a = 1'b0;
        @(posedge clk);
        #1;
        check("A_reset_clears_error", 32'(err_a), 32'h0);
        wait_ticks(1);
        rst_a = 1'b1;

        // Back in SYNC: a frame after only 50 idle ticks is ignored
        drive(1'b0, 1'b1, 50);
        frame_a(8'h33, 1'b1);
        drive(1'b0, 1'b1, 170);
        check("A_sync_ignores_frame", 32'(vld_a), 32'h0);
        rdy_a = 1'b1;
        expect_a(8'h5A);
        frame_a(8'h5A, 1'b1);
        drive(1'b0, 1'b1, 4);
        check("A_first_frame_drained", 32'(q_a.size()), 32'h0);

        // Back-to-back frames with ready held high
        for (int i = 0; i < 15; i++) begin
            expect_a(8'(i));
            frame_a(8'(i), 1'b1);
        end
        drive(1'b0, 1'b1, 4);
        check("A_b2b_drained", 32'(q_a.size()), 32'h0);
        check("A_b2b_error", 32'(err_a), 32'h0);
        check("A_b2b_overrun", 32'(novr_a), 32'h0);

        // Holding register full: second frame dropped with one overrun pulse
        rdy_a = 1'b0;
        expect_a(8'hA5);
        frame_a(8'hA5, 1'b1);
        frame_a(8'h3C, 1'b1);
        drive(1'b0, 1'b1, 4);
        check("A_ovr_valid_held", 32'(vld_a), 32'h1);
        check("A_ovr_Do_held", 32'(do_a), 32'hA5);
        check("A_ovr_pulse_count", 32'(novr_a), 32'h1);
        rdy_a = 1'b1;
        @(posedge clk);
        #1;
        check("A_valid_falls", 32'(vld_a), 32'h0);
        check("A_ovr_drained", 32'(q_a.size()), 32'h0);

        // Single-tick low at the middle sample of data bit 3 of 0xFF
        expect_a(8'hFF);
        drive(1'b0, 1'b0, 16);
        drive(1'b0, 1'b1, 56);
        drive(1'b0, 1'b0, 1);
        drive(1'b0, 1'b1, 87);
        check("A_vote_error", 32'(err_a), 32'h0);
        check("A_vote_drained", 32'(q_a.size()), 32'h0);

        // Reset in the middle of a frame drops the held word and returns to SYNC
        rdy_a = 1'b0;
        frame_a(8'h12, 1'b1);
        drive(1'b0, 1'b1, 2);
        check("A_held_before_reset", 32'(vld_a), 32'h1);
        check("A_held_Do", 32'(do_a), 32'h12);
        drive(1'b0, 1'b0, 16);
        drive(1'b0, 1'b1, 16);
        drive(1'b0, 1'b0, 16);
        rst_a = 1'b0;
        ser_a = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("A_midreset_valid", 32'(vld_a), 32'h0);
        check("A_midreset_Do", 32'(do_a), 32'h0);
        wait_ticks(1);
        rst_a = 1'b1;
        drive(1'b0, 1'b1, 159);
        drive(1'b0, 1'b0, 16);
        drive(1'b0, 1'b1, 160);
        check("A_159_idle_not_enough", 32'(vld_a), 32'h0);
        rdy_a = 1'b1;
        expect_a(8'h6C);
        frame_a(8'h6C, 1'b1);
        drive(1'b0, 1'b1, 4);
        check("A_160_idle_accepts", 32'(q_a.size()), 32'h0);

        // Stop bit 0 is a framing error
        frame_a(8'h55, 1'b0);
        drive(1'b0, 1'b1, 20);
        check("A_framing_error", 32'(err_a), 32'h1);
        check("A_framing_valid", 32'(vld_a), 32'h0);

        // Instance B: 7 data bits, odd parity, 2 stop bits
        rdy_b = 1'b1;
        drive(1'b1, 1'b1, 200);
        expect_b(7'h41, 1'b0);
        frame_b(7'h41, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 4);
        expect_b(7'h41, 1'b1);
        frame_b(7'h41, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 4);
        check("B_parity_not_fatal", 32'(err_b), 32'h0);
        check("B_drained", 32'(q_b.size()), 32'h0);
        frame_b(7'h41, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 20);
        check("B_stop2_error", 32'(err_b), 32'h1);
        check("B_stop2_valid", 32'(vld_b), 32'h0);
        check("B_overrun", 32'(novr_b), 32'h0);

        check("A_final_drained", 32'(q_a.size()), 32'h0);
        check("A_final_overrun", 32'(novr_a), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
